// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns F_PC, fetches over a req/ack instruction-memory port,
// holds the fetched word while D is stalled and flags bad fetch addresses.
//
// Handshake: imem_req is raised in S_REQ with imem_addr = F_PC held constant
// until imem_ack; imem_rdata is taken only in the ack cycle. The word is
// offered to D when F_valid=1, and it is handed over on any cycle where
// F_valid=1 and stall=0.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
   parameter logic [31:0] IMEM_HI  = 32'h0000_6FFC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [31:0] npc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] F_PC,
   output logic [31:0] F_instr,
   output logic        F_valid,
   output logic        F_adel,
   output logic [1:0]  dbg_state
);

   localparam logic [1:0] S_REQ  = 2'd0;
   localparam logic [1:0] S_HOLD = 2'd1;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        adel_q, adel_d;
   logic        handover;

   // Misaligned or outside the instruction memory window (unsigned compare).
   function automatic logic bad_addr(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a < IMEM_LO) || (a > IMEM_HI);
   endfunction

   // State register plus PC / held-instruction registers; reset wins over all.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0;
         adel_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         adel_q  <= adel_d;
      end
   end

   // Next state: latch on stalled ack, load npc at handover; a bad npc goes
   // straight to S_HOLD with a nop so no request is ever issued for it.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      adel_d   = adel_q;
      handover = 1'b0;
      case (state_q)
         S_REQ: begin
            if (imem_ack) begin
               if (stall) begin
                  instr_d = imem_rdata;
                  adel_d  = 1'b0;
                  state_d = S_HOLD;
               end else begin
                  handover = 1'b1;
               end
            end
         end
         S_HOLD: begin
            if (!stall) handover = 1'b1;
         end
         default: state_d = S_REQ;
      endcase
      if (handover) begin
         pc_d = npc;
         if (bad_addr(npc)) begin
            instr_d = 32'h0;
            adel_d  = 1'b1;
            state_d = S_HOLD;
         end else begin
            adel_d  = 1'b0;
            state_d = S_REQ;
         end
      end
   end

   // Outputs: in S_REQ the memory word passes straight through in the ack
   // cycle; in S_HOLD the latched word (or the address-error nop) is offered.
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = pc_q;
      F_PC      = pc_q;
      F_instr   = 32'h0;
      F_valid   = 1'b0;
      F_adel    = 1'b0;
      dbg_state = state_q;
      case (state_q)
         S_REQ: begin
            imem_req = 1'b1;
            F_valid  = imem_ack;
            F_instr  = imem_rdata;
         end
         S_HOLD: begin
            F_valid = 1'b1;
            F_instr = instr_q;
            F_adel  = adel_q;
         end
         default: begin
            imem_req = 1'b0;
         end
      endcase
   end

endmodule
